// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// a constant helper for sizing the iteration counter.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  // Number of bits needed to count 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shifted;

  // Trial subtraction; the remainder stays below the divisor, so the
  // difference always fits back into WIDTH bits.
  always_comb begin
    w_shifted = {i_rem, i_bit};
    o_qbit    = (w_shifted >= {1'b0, i_divisor});
    o_rem     = o_qbit ? (w_shifted[WIDTH-1:0] - i_divisor) : w_shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run one bit per cycle on magnitudes, then a FIX cycle
// applies signs and commits HI/LO. MTHI/MTLO write directly in one cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = clog2(WIDTH);

  mdu_state_e         r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_dbz;
  logic [WIDTH-1:0]   r_b;            // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_prod;         // {acc, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz_out;

  logic               w_accept_iter, w_accept_mt, w_signed_op;
  logic               w_in1_neg, w_in2_neg;
  logic [WIDTH-1:0]   w_in1_mag, w_in2_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_div_qbit;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz_out;
  assign hi          = r_hi;
  assign lo          = r_lo;

  assign w_accept_iter = start && (r_state == S_IDLE) && (op <= MDU_DIVU);
  assign w_accept_mt   = start && (r_state == S_IDLE) && ((op == MDU_MTHI) || (op == MDU_MTLO));

  // Operand magnitudes and sign flags; MULT and DIV have even op codes.
  always_comb begin
    w_signed_op = ~op[0];
    w_in1_neg   = w_signed_op & in1[WIDTH-1];
    w_in2_neg   = w_signed_op & in2[WIDTH-1];
    w_in1_mag   = w_in1_neg ? -in1 : in1;
    w_in2_mag   = w_in2_neg ? -in2 : in2;
  end

  // Shift-add step: add the multiplicand when the multiplier LSB is set.
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_b};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_prod[2*WIDTH-1:WIDTH]),
    .i_bit     (r_prod[WIDTH-1]),
    .i_divisor (r_b),
    .o_rem     (w_div_rem),
    .o_qbit    (w_div_qbit)
  );

  // Sign correction of the finished magnitude result. With a zero divisor
  // the remainder equals |in1|, so negating it by the dividend sign yields
  // in1 unchanged; only LO needs the explicit all-ones override.
  always_comb begin
    if (r_is_div) begin
      w_fix_hi = r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = r_dbz ? '1 : (r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0]);
    end else begin
      {w_fix_hi, w_fix_lo} = r_neg_q ? -r_prod : r_prod;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept_iter) w_next_state = S_RUN;
      S_RUN:   if (r_cnt == '0)   w_next_state = S_FIX;
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Iteration datapath: latch operands on accept, then one step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: working registers are reset too, so a reset mid-operation
    // leaves no stale partial result and simulation never sees X here.
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_b      <= '0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept_iter) begin
          r_cnt    <= CNT_W'(WIDTH - 1);
          r_is_div <= op[1];
          r_neg_q  <= w_in1_neg ^ w_in2_neg;
          r_neg_r  <= w_in1_neg;
          r_dbz    <= op[1] && (in2 == '0);
          if (op[1]) begin
            r_prod <= {{WIDTH{1'b0}}, w_in1_mag};
            r_b    <= w_in2_mag;
          end else begin
            r_prod <= {{WIDTH{1'b0}}, w_in2_mag};
            r_b    <= w_in1_mag;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_is_div) r_prod <= {w_div_rem, r_prod[WIDTH-2:0], w_div_qbit};
          else if (r_prod[0]) r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
          else r_prod <= {1'b0, r_prod[2*WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO and the done / div_by_zero pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      if (w_accept_mt) begin
        if (op == MDU_MTHI) r_hi <= in1;
        else                r_lo <= in1;
        r_done <= 1'b1;
      end else if (r_state == S_FIX) begin
        r_hi      <= w_fix_hi;
        r_lo      <= w_fix_lo;
        r_done    <= 1'b1;
        r_dbz_out <= r_dbz;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] in1, in2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue an iterative op at a negedge, scramble inputs after acceptance,
  // then wait (bounded) for done and check timing and results.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edbz);
    int cyc, busy_cyc, hold_err;
    logic [W-1:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0; op = MDU_MTHI; in1 = ~a; in2 = ~b;
    busy_cyc = busy ? 1 : 0;
    hold_err = (hi !== hi0 || lo !== lo0) ? 1 : 0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (busy) busy_cyc++;
      if (hi !== hi0 || lo !== lo0) hold_err++;
    end
    check({tag, " latency"}, cyc, 33);
    check({tag, " busy_cycles"}, busy_cyc, 33);
    check({tag, " hilo_hold"}, hold_err, 0);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    check({tag, " dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    int cyc, n_done;
    rst = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst dbz", div_by_zero, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1; op = MDU_MTHI; in1 = 32'h0000_A5A5;
    @(negedge clk);
    check("mthi done", done, 1);
    check("mthi busy", busy, 0);
    check("mthi hi", hi, 32'h0000_A5A5);
    op = MDU_MTLO; in1 = 32'h0000_5A5A;
    @(negedge clk);
    start = 1'b0;
    check("mtlo done", done, 1);
    check("mtlo busy", busy, 0);
    check("mtlo lo", lo, 32'h0000_5A5A);
    check("mtlo hi keep", hi, 32'h0000_A5A5);
    @(negedge clk);
    check("mt done pulse", done, 0);

    // Reserved op is ignored.
    start = 1'b1; op = 3'd6; in1 = 32'h1111_2222;
    @(negedge clk);
    start = 1'b0;
    check("rsv done", done, 0);
    check("rsv busy", busy, 0);
    check("rsv hi", hi, 32'h0000_A5A5);
    check("rsv lo", lo, 32'h0000_5A5A);

    // Reset during RUN aborts the op immediately.
    start = 1'b1; op = MDU_MULT; in1 = 32'd3; in2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-rst busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst hi", hi, 0);
    check("midrst lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst no_done", n_done, 0);

    run_op("mult -2*3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult big", MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0);
    run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 100/-7", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
    run_op("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu /0", MDU_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run_op("divu 7/2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("div -7/0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back: MTLO issued in the cycle done is high.
    start = 1'b1; op = MDU_MTLO; in1 = 32'h0000_0077;
    @(negedge clk);
    start = 1'b0;
    check("b2b done", done, 1);
    check("b2b lo", lo, 32'h0000_0077);
    check("b2b dbz", div_by_zero, 0);
    check("b2b hi", hi, 32'hFFFF_FFF9);

    // Start while busy is ignored.
    start = 1'b1; op = MDU_MULTU; in1 = 32'd5; in2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MTHI; in1 = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0;
    check("busy-start hi", hi, 32'hFFFF_FFF9);
    check("busy-start done", done, 0);
    check("busy-start busy", busy, 1);
    cyc = 5;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    check("busy-start latency", cyc, 33);
    check("busy-start res hi", hi, 0);
    check("busy-start res lo", lo, 32'd30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
